// File: rtl/signed_calc_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : signed_calc_seq_ctrl                                           |
// | Brief   : Six-step shift-add sequencer, o_fs = 7A - 3B + 6C (wrapping),  |
// |           one shared add/sub unit. SIGNED_CALC_OVF_EN adds o_ovf.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module signed_calc_seq_ctrl #(
  parameter int WIDTH_IN  = 4,
  parameter int WIDTH_OUT = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WIDTH_IN-1:0]  i_as,
  input  logic [WIDTH_IN-1:0]  i_bs,
  input  logic [WIDTH_IN-1:0]  i_cs,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [WIDTH_OUT-1:0] o_fs,
`ifdef SIGNED_CALC_OVF_EN
  output logic                 o_ovf,
`endif
  output logic                 o_busy
);

`ifdef SIGNED_CALC_OVF_EN
  localparam int c_guard = 2;
`else
  localparam int c_guard = 0;
`endif
  localparam int c_acc_w = WIDTH_OUT + c_guard;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_calc = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;
  localparam logic [2:0] c_last_step = 3'd5;

  generate
    if (WIDTH_OUT < WIDTH_IN + 4) begin : g_width_check
      $error("signed_calc_seq_ctrl: WIDTH_OUT must be >= WIDTH_IN+4");
    end
  endgenerate

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [2:0]         r_step;
  logic [c_acc_w-1:0] r_a;
  logic [c_acc_w-1:0] r_b;
  logic [c_acc_w-1:0] r_c;
  logic [c_acc_w-1:0] r_acc;
  logic [c_acc_w-1:0] w_opd;
  logic               w_sub;
  logic [c_acc_w-1:0] w_sum;
  logic [WIDTH_OUT-1:0] r_fs;
  logic               w_accept;
  logic               w_last;

  assign w_accept = i_valid & o_ready;
  assign w_last   = (r_step >= c_last_step);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Unencoded state values fall through to IDLE.
  always_comb begin
    w_state_nxt = c_st_idle;
    case (r_state)
      c_st_idle: w_state_nxt = i_valid ? c_st_calc : c_st_idle;
      c_st_calc: w_state_nxt = w_last  ? c_st_done : c_st_calc;
      c_st_done: w_state_nxt = i_ready ? c_st_idle : c_st_done;
      default:   w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    o_ready = 1'b0;
    o_valid = 1'b0;
    o_busy  = 1'b0;
    case (r_state)
      c_st_idle: o_ready = 1'b1;
      c_st_calc: o_busy  = 1'b1;
      c_st_done: begin
        o_valid = 1'b1;
        o_busy  = 1'b1;
      end
      default: ;
    endcase
  end

  // Shift-add schedule: +8A -A -2B -B +4C +2C.
  always_comb begin
    w_opd = '0;
    w_sub = 1'b0;
    case (r_step)
      3'd0: w_opd = r_a << 3;
      3'd1: begin w_opd = r_a;      w_sub = 1'b1; end
      3'd2: begin w_opd = r_b << 1; w_sub = 1'b1; end
      3'd3: begin w_opd = r_b;      w_sub = 1'b1; end
      3'd4: w_opd = r_c << 2;
      3'd5: w_opd = r_c << 1;
      default: ;
    endcase
  end

  assign w_sum = r_acc + (w_sub ? ~w_opd : w_opd) + {{(c_acc_w-1){1'b0}}, w_sub};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_c    <= '0;
      r_acc  <= '0;
      r_step <= '0;
      r_fs   <= '0;
    end else if (w_accept) begin
      r_a    <= {{(c_acc_w-WIDTH_IN){1'b0}}, i_as};
      r_b    <= {{(c_acc_w-WIDTH_IN){1'b0}}, i_bs};
      r_c    <= {{(c_acc_w-WIDTH_IN){1'b0}}, i_cs};
      r_acc  <= '0;
      r_step <= '0;
    end else if (r_state == c_st_calc) begin
      r_acc  <= w_sum;
      r_step <= r_step + 3'd1;
      if (w_last) begin
        r_fs <= w_sum[WIDTH_OUT-1:0];
      end
    end
  end

  assign o_fs = r_fs;

`ifdef SIGNED_CALC_OVF_EN
  logic r_ovf;

  // Guard bits are 00 only when the true result lies in [0, 2^WIDTH_OUT-1].
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ovf <= 1'b0;
    end else if (!w_accept && (r_state == c_st_calc) && w_last) begin
      r_ovf <= |w_sum[c_acc_w-1:WIDTH_OUT];
    end
  end

  assign o_ovf = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_signed_calc_seq_ctrl.sv
`default_nettype none
// Bench for signed_calc_seq_ctrl: cycle-level behavioural model plus directed
// vectors with hand-computed results.
module tb_signed_calc_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       i_valid;
  logic       o_ready;
  logic [3:0] i_as;
  logic [3:0] i_bs;
  logic [3:0] i_cs;
  logic       o_valid;
  logic       i_ready;
  logic [7:0] o_fs;
  logic       o_busy;
`ifdef SIGNED_CALC_OVF_EN
  logic       o_ovf;
`endif

  signed_calc_seq_ctrl #(.WIDTH_IN(4), .WIDTH_OUT(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_as    (i_as),
    .i_bs    (i_bs),
    .i_cs    (i_cs),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_fs    (o_fs),
`ifdef SIGNED_CALC_OVF_EN
    .o_ovf   (o_ovf),
`endif
    .o_busy  (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic int calc(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    return 7 * int'(a) - 3 * int'(b) + 6 * int'(c);
  endfunction

  // Model: phase 0 idle, 1 computing (m_left clocks to go), 2 result held.
  int         m_phase = 0;
  int         m_left  = 0;
  int         m_res   = 0;
  logic [7:0] m_fs    = 8'h00;
  logic       m_ovf   = 1'b0;
  bit         m_known = 0;

  int         cyc = 0;
  logic       prev_ready = 1'b0;
  logic       prev_valid = 1'b0;
  int         acc_times[$];
  logic [7:0] got_q[$];

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_phase = 0;
      m_fs    = 8'h00;
      m_ovf   = 1'b0;
      m_known = 1;
    end else if (m_known) begin
      case (m_phase)
        0: if (i_valid) begin
          m_res   = calc(i_as, i_bs, i_cs);
          m_left  = 6;
          m_phase = 1;
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            m_phase = 2;
            m_fs    = m_res[7:0];
            m_ovf   = (m_res < 0) || (m_res > 255);
          end
        end
        default: if (i_ready) m_phase = 0;
      endcase
    end
    #1;
    if (m_known) begin
      chk("ready", {31'd0, o_ready}, {31'd0, m_phase == 0});
      chk("valid", {31'd0, o_valid}, {31'd0, m_phase == 2});
      chk("busy",  {31'd0, o_busy},  {31'd0, m_phase != 0});
      chk("fs",    {24'd0, o_fs},    {24'd0, m_fs});
`ifdef SIGNED_CALC_OVF_EN
      if (m_phase == 2) chk("ovf", {31'd0, o_ovf}, {31'd0, m_ovf});
`endif
      if (prev_ready && o_busy) acc_times.push_back(cyc);
      if (prev_valid && !o_valid && rst_n) got_q.push_back(o_fs);
    end
    prev_ready = o_ready;
    prev_valid = o_valid;
  end

  // One operation: accept, junk on inputs during CALC, optional stall in DONE.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input int hold, input logic [7:0] exp_fs, input logic exp_ovf);
    int lat;
    bit seen;
    @(negedge clk);
    i_valid = 1'b1; i_as = a; i_bs = b; i_cs = c;
    i_ready = (hold == 0);
    @(posedge clk);
    lat  = 1;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      i_valid = k[0];
      i_as = 4'($urandom); i_bs = 4'($urandom); i_cs = 4'($urandom);
      @(posedge clk);
      lat++;
      #1;
      if (o_valid) seen = 1;
    end
    chk("latency", lat, seen ? 7 : 0);
    chk("fs_literal", {24'd0, o_fs}, {24'd0, exp_fs});
`ifdef SIGNED_CALC_OVF_EN
    chk("ovf_literal", {31'd0, o_ovf}, {31'd0, exp_ovf});
`else
    if (exp_ovf === 1'bx) chk("ovf_unused", 0, 1);
`endif
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      i_valid = ~k[0];
      i_as = 4'($urandom); i_bs = 4'($urandom); i_cs = 4'($urandom);
      @(posedge clk);
      #1;
      chk("hold_valid", {31'd0, o_valid}, 32'd1);
      chk("hold_ready", {31'd0, o_ready}, 32'd0);
      chk("hold_fs", {24'd0, o_fs}, {24'd0, exp_fs});
    end
    @(negedge clk);
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("back_to_idle", {31'd0, o_ready}, 32'd1);
  endtask

  logic [3:0] ta[3] = '{4'd3, 4'd9, 4'd0};
  logic [3:0] tb_[3] = '{4'd4, 4'd1, 4'd5};
  logic [3:0] tc[3] = '{4'd5, 4'd2, 4'd7};
  logic [7:0] texp[3] = '{8'd39, 8'd72, 8'd27};

  initial begin
    int n;
    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_as = 4'd0; i_bs = 4'd0; i_cs = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, o_ready}, 32'd1);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_fs", {24'd0, o_fs}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(4'd5,  4'd2,  4'd3,  0, 8'h2F, 1'b0);
    run_op(4'd0,  4'd15, 4'd0,  0, 8'hD3, 1'b1);
    run_op(4'd15, 4'd0,  4'd15, 0, 8'hC3, 1'b0);
    run_op(4'd0,  4'd0,  4'd0,  0, 8'h00, 1'b0);
    run_op(4'd1,  4'd1,  4'd1,  5, 8'h0A, 1'b0);

    // Back-to-back with both handshakes held high.
    got_q.delete();
    acc_times.delete();
    @(negedge clk);
    i_ready = 1'b1; i_valid = 1'b1;
    i_as = ta[0]; i_bs = tb_[0]; i_cs = tc[0];
    n = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (acc_times.size() != n) begin
        n = acc_times.size();
        if (n < 3) begin
          i_as = ta[n]; i_bs = tb_[n]; i_cs = tc[n];
        end else begin
          i_valid = 1'b0;
        end
      end
      if (n >= 3 && got_q.size() >= 3) break;
    end
    i_valid = 1'b0;
    chk("tp_count", got_q.size(), 3);
    for (int k = 0; k < 3; k++) begin
      if (k < got_q.size()) chk("tp_result", {24'd0, got_q[k]}, {24'd0, texp[k]});
      else chk("tp_missing", 0, 1);
    end
    if (acc_times.size() >= 3) begin
      chk("tp_spacing1", acc_times[1] - acc_times[0], 8);
      chk("tp_spacing2", acc_times[2] - acc_times[1], 8);
    end else begin
      chk("tp_accepts", acc_times.size(), 3);
    end

    // Reset while step 3 is due.
    @(negedge clk);
    i_valid = 1'b1; i_as = 4'd7; i_bs = 4'd3; i_cs = 4'd9;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_ready", {31'd0, o_ready}, 32'd1);
    chk("midrst_valid", {31'd0, o_valid}, 32'd0);
    chk("midrst_fs", {24'd0, o_fs}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(4'd2, 4'd6, 4'd1, 1, 8'h02, 1'b0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
